// File: rtl/floppy_bus_pkg.sv
// Shared register-map constants for the floppy bus port.
package floppy_bus_pkg;

  // Register offsets inside the 4-byte window
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_offset_e;

  // STATUS bit positions
  localparam int ST_RX_EMPTY   = 0;
  localparam int ST_RX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_TX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_IRQ_ACTIVE = 7;

  // CTRL bit positions
  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;
  localparam int CTRL_OVR_CLEAR = 7;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through output.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and fill-level bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: all state in clocked blocks uses <= so every register samples pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte storage
  // NOTE: storage is deliberately not reset; emptiness comes from the pointers, so this maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/floppy_bus_port.sv
// 6502 bus responder exposing a 4-byte register window that bridges the CPU
// to the floppy RX/TX byte streams and drives the active-low CPU interrupt.
module floppy_bus_port
  import floppy_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hC000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [7:0]  data_wr,
  input  logic        rw,
  output logic [7:0]  data_rd,
  output logic        sel,
  output logic        irqn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic          rd;
  logic          wr;
  reg_offset_e   offset;

  logic          rx_pop;
  logic          tx_push;
  logic [7:0]    rx_dout;
  logic          rx_empty;
  logic          rx_full;
  logic [CW-1:0] rx_count;
  logic          tx_empty;
  logic          tx_full;
  // TX fill level is not exposed on the register map
  logic [CW-1:0] tx_count_unused;

  logic [1:0]    ctrl;
  logic          rx_overrun;
  logic          ovr_set;
  logic          ovr_clr;
  logic          irq_active;
  logic [7:0]    status;
  logic [7:0]    rd_value;

  // Address decode: one access per decoded cycle, no edge detection needed
  assign hit    = (address[15:2] == BASE_ADDR[15:2]);
  assign rd     = hit & rw;
  assign wr     = hit & ~rw;
  assign offset = reg_offset_e'(address[1:0]);

  assign rx_pop  = rd & (offset == REG_DATA);
  assign tx_push = wr & (offset == REG_DATA);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (data_wr),
    .pop   (tx_ready),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count_unused)
  );

  assign tx_valid = ~tx_empty;

  // A push into a full RX FIFO is lost unless a CPU pop frees a slot this cycle
  assign ovr_set = rx_valid & rx_full & ~rx_pop;
  assign ovr_clr = wr & (offset == REG_CTRL) & data_wr[CTRL_OVR_CLEAR];

  assign irq_active = (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty)
                    | (ctrl[CTRL_TX_IRQ_EN] &  tx_empty)
                    | rx_overrun;

  // CTRL enables and sticky overrun flag; a new overrun wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr && offset == REG_CTRL) begin
        ctrl <= data_wr[1:0];
      end
      if (ovr_set) begin
        rx_overrun <= 1'b1;
      end else if (ovr_clr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  // STATUS word assembled from live flags
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    status                = 8'h00;
    status[ST_RX_EMPTY]   = rx_empty;
    status[ST_RX_FULL]    = rx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_TX_FULL]    = tx_full;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_IRQ_ACTIVE] = irq_active;
  end

  // Read mux: DATA returns the pre-pop head, or zero when RX is empty
  always_comb begin
    rd_value = 8'h00;
    case (offset)
      REG_DATA:   rd_value = rx_empty ? 8'h00 : rx_dout;
      REG_STATUS: rd_value = status;
      REG_CTRL:   rd_value = {6'b0, ctrl};
      REG_COUNT:  rd_value = 8'(rx_count);
      default:    rd_value = 8'h00;
    endcase
  end

  // Registered bus outputs and interrupt line
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd <= 8'h00;
      sel     <= 1'b0;
      irqn    <= 1'b1;
    end else begin
      data_rd <= rd ? rd_value : 8'h00;
      sel     <= rd;
      irqn    <= ~irq_active;
    end
  end

endmodule

// File: tb/tb_floppy_bus_port.sv
// Self-checking bench for floppy_bus_port: directed scenarios plus a
// randomized run, all checked against a queue-based register-map model.
module tb_floppy_bus_port;

  localparam logic [15:0] BASE  = 16'hC000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_wr = 8'h00;
  logic        rw = 1'b1;
  logic [7:0]  data_rd;
  logic        sel;
  logic        irqn;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [1:0] m_ctrl = 2'b00;
  logic       m_ovr  = 1'b0;
  logic [7:0] exp_data_rd;
  logic       exp_sel;
  logic       exp_irqn;
  logic       exp_tx_valid;
  logic [7:0] exp_tx_data;
  logic       tb_tx_ready = 1'b0;

  floppy_bus_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_wr  (data_wr),
    .rw       (rw),
    .data_rd  (data_rd),
    .sel      (sel),
    .irqn     (irqn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one bus/stream cycle, advance the model, wait past the edge
  task automatic step(input logic r, input logic [15:0] a, input logic rw_i,
                      input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                      input logic txr);
    bit         in_win;
    bit         is_rd;
    bit         is_wr;
    int         off;
    bit         irq_now;
    bit         dropped;
    logic [7:0] st;
    logic [7:0] rv;
    rst = r; address = a; rw = rw_i; data_wr = wd;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr;
    if (r) begin
      rxq.delete(); txq.delete();
      m_ctrl = 2'b00; m_ovr = 1'b0;
      exp_data_rd = 8'h00; exp_sel = 1'b0; exp_irqn = 1'b1;
    end else begin
      in_win  = (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 3);
      off     = int'(a) - int'(BASE);
      is_rd   = in_win && rw_i;
      is_wr   = in_win && !rw_i;
      dropped = 0;
      irq_now = (m_ctrl[0] && rxq.size() > 0) || (m_ctrl[1] && txq.size() == 0) || m_ovr;
      st = 8'((rxq.size() == 0) ? 1 : 0) + 8'((rxq.size() == DEPTH) ? 2 : 0)
         + 8'((txq.size() == 0) ? 4 : 0) + 8'((txq.size() == DEPTH) ? 8 : 0)
         + 8'(m_ovr ? 16 : 0) + 8'(irq_now ? 128 : 0);
      rv = 8'h00;
      if (is_rd) begin
        case (off)
          0: rv = (rxq.size() > 0) ? rxq[0] : 8'h00;
          1: rv = st;
          2: rv = {6'b0, m_ctrl};
          default: rv = 8'(rxq.size());
        endcase
      end
      exp_data_rd = rv;
      exp_sel     = is_rd;
      exp_irqn    = !irq_now;
      if (is_rd && off == 0 && rxq.size() > 0) void'(rxq.pop_front());
      if (rxv) begin
        if (rxq.size() < DEPTH) rxq.push_back(rxd);
        else dropped = 1;
      end
      if (is_wr && off == 2) begin
        m_ctrl = wd[1:0];
        if (wd[7]) m_ovr = 1'b0;
      end
      if (dropped) m_ovr = 1'b1;
      if (txr && txq.size() > 0) void'(txq.pop_front());
      if (is_wr && off == 0 && txq.size() < DEPTH) txq.push_back(wd);
    end
    exp_tx_valid = (txq.size() > 0);
    exp_tx_data  = exp_tx_valid ? txq[0] : 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, tb_tx_ready);
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    step(1'b0, a, 1'b1, 8'h00, 1'b0, 8'h00, tb_tx_ready);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    step(1'b0, a, 1'b0, d, 1'b0, 8'h00, tb_tx_ready);
  endtask

  task automatic rx_push(input logic [7:0] d);
    step(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, d, tb_tx_ready);
  endtask

  task automatic test_reset();
    step(1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    tb_tx_ready = 1'b0;
    rx_push(8'h12); rx_push(8'h34);
    cpu_wr(BASE, 8'h56);
    // reset mid-operation with stream and bus activity pending
    step(1'b1, BASE, 1'b0, 8'hAB, 1'b1, 8'hCD, 1'b0);
    step(1'b1, BASE, 1'b0, 8'hAB, 1'b1, 8'hCD, 1'b0);
    tests_run++;
    if (data_rd !== 8'h00) begin tests_failed++; $display("FAIL reset_data_rd: got %h want 00", data_rd); end
    tests_run++;
    if (sel !== 1'b0) begin tests_failed++; $display("FAIL reset_sel: got %b want 0", sel); end
    tests_run++;
    if (irqn !== 1'b1) begin tests_failed++; $display("FAIL reset_irqn: got %b want 1", irqn); end
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    cpu_rd(BASE + 16'd3);
    tests_run++;
    if (data_rd !== 8'h00 || sel !== 1'b1) begin
      tests_failed++; $display("FAIL reset_count: data_rd=%h sel=%b want 00/1", data_rd, sel);
    end
    cpu_rd(BASE + 16'd1);
    tests_run++;
    if (data_rd !== 8'h05) begin tests_failed++; $display("FAIL reset_status: got %h want 05", data_rd); end
  endtask

  task automatic test_rx_path();
    rx_push(8'hA5); rx_push(8'h3C);
    idle();
    tests_run++;
    if (sel !== 1'b0 || data_rd !== 8'h00) begin
      tests_failed++; $display("FAIL rx_idle: sel=%b data_rd=%h want 0/00", sel, data_rd);
    end
    cpu_rd(BASE + 16'd3);
    tests_run++;
    if (data_rd !== 8'h02) begin tests_failed++; $display("FAIL rx_count: got %h want 02", data_rd); end
    cpu_rd(BASE);
    tests_run++;
    if (data_rd !== 8'hA5 || sel !== 1'b1) begin
      tests_failed++; $display("FAIL rx_pop1: data_rd=%h sel=%b want a5/1", data_rd, sel);
    end
    cpu_rd(BASE);
    tests_run++;
    if (data_rd !== 8'h3C) begin tests_failed++; $display("FAIL rx_pop2: got %h want 3c", data_rd); end
    cpu_rd(BASE);
    tests_run++;
    if (data_rd !== 8'h00) begin tests_failed++; $display("FAIL rx_pop_empty: got %h want 00", data_rd); end
    cpu_rd(BASE + 16'd1);
    tests_run++;
    if (data_rd[0] !== 1'b1) begin tests_failed++; $display("FAIL rx_empty_flag: status=%h want b0=1", data_rd); end
  endtask

  task automatic test_overrun();
    tb_tx_ready = 1'b0;
    cpu_wr(BASE, 8'h77);
    for (int i = 0; i < DEPTH + 1; i++) rx_push(8'(8'h40 + i));
    cpu_rd(BASE + 16'd1);
    tests_run++;
    if (data_rd !== 8'h92) begin tests_failed++; $display("FAIL ovr_status: got %h want 92", data_rd); end
    tests_run++;
    if (irqn !== 1'b0) begin tests_failed++; $display("FAIL ovr_irqn: got %b want 0", irqn); end
    cpu_wr(BASE + 16'd2, 8'h80);
    tests_run++;
    if (irqn !== 1'b0) begin tests_failed++; $display("FAIL ovr_clr_edge_irqn: got %b want 0", irqn); end
    idle();
    tests_run++;
    if (irqn !== 1'b1) begin tests_failed++; $display("FAIL ovr_clr_irqn: got %b want 1", irqn); end
    cpu_rd(BASE + 16'd1);
    tests_run++;
    if (data_rd !== 8'h02) begin tests_failed++; $display("FAIL ovr_cleared_status: got %h want 02", data_rd); end
  endtask

  task automatic test_full_push_pop();
    step(1'b0, BASE, 1'b1, 8'h00, 1'b1, 8'hEE, 1'b0);
    tests_run++;
    if (data_rd !== 8'h40) begin tests_failed++; $display("FAIL fullpp_data: got %h want 40", data_rd); end
    cpu_rd(BASE + 16'd3);
    tests_run++;
    if (data_rd !== 8'h10) begin tests_failed++; $display("FAIL fullpp_count: got %h want 10", data_rd); end
    cpu_rd(BASE + 16'd1);
    tests_run++;
    if (data_rd !== 8'h02) begin tests_failed++; $display("FAIL fullpp_no_ovr: got %h want 02", data_rd); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] want;
      want = (i < DEPTH - 1) ? 8'(8'h41 + i) : 8'hEE;
      cpu_rd(BASE);
      tests_run++;
      if (data_rd !== want) begin
        tests_failed++; $display("FAIL fullpp_drain[%0d]: got %h want %h", i, data_rd, want);
      end
    end
  endtask

  task automatic test_tx_path();
    int n;
    tb_tx_ready = 1'b1;
    n = 0;
    while (tx_valid !== 1'b0 && n < 40) begin idle(); n++; end
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_drain_timeout: tx_valid=%b want 0", tx_valid); end
    tb_tx_ready = 1'b0;
    cpu_wr(BASE, 8'h11);
    cpu_wr(BASE, 8'h22);
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      tests_failed++; $display("FAIL tx_head: valid=%b data=%h want 1/11", tx_valid, tx_data);
    end
    tb_tx_ready = 1'b1;
    idle();
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
      tests_failed++; $display("FAIL tx_second: valid=%b data=%h want 1/22", tx_valid, tx_data);
    end
    idle();
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL tx_empty_after: got %b want 0", tx_valid); end
  endtask

  task automatic test_irq_enables();
    tb_tx_ready = 1'b0;
    cpu_wr(BASE + 16'd2, 8'h02);
    tests_run++;
    if (irqn !== 1'b1) begin tests_failed++; $display("FAIL irq_en_edge: got %b want 1", irqn); end
    idle();
    tests_run++;
    if (irqn !== 1'b0) begin tests_failed++; $display("FAIL irq_tx_empty: got %b want 0", irqn); end
    cpu_wr(BASE, 8'h55);
    tests_run++;
    if (irqn !== 1'b0) begin tests_failed++; $display("FAIL irq_push_edge: got %b want 0", irqn); end
    idle();
    tests_run++;
    if (irqn !== 1'b1) begin tests_failed++; $display("FAIL irq_tx_nonempty: got %b want 1", irqn); end
    cpu_rd(BASE + 16'd4);
    tests_run++;
    if (sel !== 1'b0 || data_rd !== 8'h00) begin
      tests_failed++; $display("FAIL offwin_read: sel=%b data_rd=%h want 0/00", sel, data_rd);
    end
    cpu_wr(BASE + 16'd4, 8'h33);
    tb_tx_ready = 1'b1;
    idle();
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL offwin_write: tx_valid=%b want 0", tx_valid); end
    cpu_wr(BASE + 16'd2, 8'h00);
    cpu_rd(BASE + 16'd2);
    tests_run++;
    if (data_rd !== 8'h00) begin tests_failed++; $display("FAIL ctrl_readback: got %h want 00", data_rd); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic        r;
      logic        rxv;
      logic        txr;
      int          phase;
      phase = (i / 300) % 3;
      a   = ($urandom_range(0, 9) < 8) ? (BASE + 16'($urandom_range(0, 3))) : 16'($urandom);
      r   = ($urandom_range(0, 299) == 0);
      rxv = ($urandom_range(0, 9) < ((phase == 0) ? 7 : 3));
      txr = ($urandom_range(0, 9) < ((phase == 1) ? 1 : 5));
      step(r, a, 1'($urandom), 8'($urandom), rxv, 8'($urandom), txr);
      tests_run++;
      if (data_rd !== exp_data_rd) begin
        tests_failed++; $display("FAIL rand_data_rd[%0d]: got %h want %h", i, data_rd, exp_data_rd);
      end
      tests_run++;
      if (sel !== exp_sel) begin
        tests_failed++; $display("FAIL rand_sel[%0d]: got %b want %b", i, sel, exp_sel);
      end
      tests_run++;
      if (irqn !== exp_irqn) begin
        tests_failed++; $display("FAIL rand_irqn[%0d]: got %b want %b", i, irqn, exp_irqn);
      end
      tests_run++;
      if (tx_valid !== exp_tx_valid || (exp_tx_valid && tx_data !== exp_tx_data)) begin
        tests_failed++;
        $display("FAIL rand_tx[%0d]: valid=%b data=%h want %b/%h", i, tx_valid, tx_data, exp_tx_valid, exp_tx_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rx_path();
    test_overrun();
    test_full_push_pop();
    test_tx_path();
    test_irq_enables();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
